// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        PORT_M0 = 1'b0,
        PORT_M1 = 1'b1
    } port_e;

    localparam int DW_DEF       = 8;
    localparam int AW_DEF       = 8;
    localparam int LOCK_MAX_DEF = 16;

    // Width of a counter that must hold values 0..lock_max inclusive.
    function automatic int lock_cnt_w(input int lock_max);
        return $clog2(lock_max + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: combinational grant plus the last-grant register.
module rr_arb2 (
    input  logic       clk,
    input  logic       sync_nreset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    import mem_arb_pkg::*;

    port_e      last_grant_d;
    port_e      last_grant_q;
    logic [1:0] gnt_s;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        gnt_s = 2'b00;
        case (req)
            2'b01:   gnt_s = 2'b01;
            2'b10:   gnt_s = 2'b10;
            2'b11:   gnt_s = (last_grant_q == PORT_M1) ? 2'b01 : 2'b10;
            default: gnt_s = 2'b00;
        endcase
    end

    // Remember the winner of any granted cycle.
    always_comb begin
        if (gnt_s[0]) begin
            last_grant_d = PORT_M0;
        end else if (gnt_s[1]) begin
            last_grant_d = PORT_M1;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Reset to port 1 so port 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (!sync_nreset) begin
            last_grant_q <= PORT_M1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single registered-read memory port.
// Optional bus locking is enabled by defining MEM_ARB_LOCK_EN.
module mem_arbiter #(
    parameter int DW       = mem_arb_pkg::DW_DEF,
    parameter int AW       = mem_arb_pkg::AW_DEF,
    parameter int LOCK_MAX = mem_arb_pkg::LOCK_MAX_DEF
) (
    input  logic          clk,
    input  logic          sync_nreset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic          m0_lock,
    input  logic          m1_lock,
`endif
    output logic [AW-1:0] mem_addr_out,
    output logic [DW-1:0] mem_data_out,
    output logic          mem_write,
    input  logic [DW-1:0] mem_data_in
);
    import mem_arb_pkg::*;

    localparam int            CW       = lock_cnt_w(LOCK_MAX);
    localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_MAX);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]    lock_s;
    logic [1:0]    mask_s;
    logic [1:0]    req_s;
    logic [1:0]    gnt_s;
    logic          owned_s;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] wdata_s;
    logic          write_s;

    logic          rd_pend_d,  rd_pend_q;
    port_e         rd_owner_d, rd_owner_q;
    logic          own_vld_d,  own_vld_q;
    port_e         own_d,      own_q;
    logic [CW-1:0] lock_cnt_d, lock_cnt_q;

`ifdef MEM_ARB_LOCK_EN
    assign lock_s = {m1_lock, m0_lock};
`else
    assign lock_s = 2'b00;
`endif

    // Ownership holds while the owner keeps lock and has not used up LOCK_MAX cycles.
    assign owned_s = own_vld_q & lock_s[own_q] & (lock_cnt_q != LOCK_LIM);

    always_comb begin
        if (owned_s) begin
            mask_s = (own_q == PORT_M0) ? 2'b10 : 2'b01;
        end else begin
            mask_s = 2'b00;
        end
    end

    assign req_s = {m1_req & ~mask_s[1], m0_req & ~mask_s[0]} & {2{sync_nreset}};

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .sync_nreset (sync_nreset),
        .req         (req_s),
        .gnt         (gnt_s)
    );

    // Steer the granted port onto the memory pins; idle paths drive zero.
    always_comb begin
        addr_s  = {AW{1'b0}};
        wdata_s = {DW{1'b0}};
        write_s = 1'b0;
        if (gnt_s[0]) begin
            addr_s  = m0_addr;
            write_s = m0_we;
            wdata_s = m0_we ? m0_wdata : {DW{1'b0}};
        end else if (gnt_s[1]) begin
            addr_s  = m1_addr;
            write_s = m1_we;
            wdata_s = m1_we ? m1_wdata : {DW{1'b0}};
        end else begin
            addr_s  = {AW{1'b0}};
            wdata_s = {DW{1'b0}};
            write_s = 1'b0;
        end
    end

    // A granted read returns data on the following cycle to its owner.
    always_comb begin
        rd_pend_d  = (gnt_s[0] & ~m0_we) | (gnt_s[1] & ~m1_we);
        rd_owner_d = gnt_s[1] ? PORT_M1 : PORT_M0;
    end

    // Lock ownership and the consecutive-owned-cycle counter.
    always_comb begin
        own_vld_d  = 1'b0;
        own_d      = own_q;
        lock_cnt_d = {CW{1'b0}};
        if (owned_s) begin
            own_vld_d  = 1'b1;
            lock_cnt_d = lock_cnt_q + CNT_ONE;
        end else if (gnt_s[0] & lock_s[0]) begin
            own_vld_d = 1'b1;
            own_d     = PORT_M0;
        end else if (gnt_s[1] & lock_s[1]) begin
            own_vld_d = 1'b1;
            own_d     = PORT_M1;
        end else begin
            own_vld_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!sync_nreset) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= PORT_M0;
            own_vld_q  <= 1'b0;
            own_q      <= PORT_M0;
            lock_cnt_q <= {CW{1'b0}};
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            own_vld_q  <= own_vld_d;
            own_q      <= own_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign m0_gnt       = gnt_s[0];
    assign m1_gnt       = gnt_s[1];
    assign mem_addr_out = addr_s;
    assign mem_data_out = wdata_s;
    assign mem_write    = write_s;

    assign m0_rvalid = rd_pend_q & (rd_owner_q == PORT_M0);
    assign m1_rvalid = rd_pend_q & (rd_owner_q == PORT_M1);
    assign m0_rdata  = m0_rvalid ? mem_data_in : {DW{1'b0}};
    assign m1_rdata  = m1_rvalid ? mem_data_in : {DW{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a registered-read memory model.
module tb_mem_arbiter;

    logic       clk;
    logic       sync_nreset;
    logic       m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [7:0] m0_addr, m0_wdata, m0_rdata;
    logic       m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [7:0] m1_addr, m1_wdata, m1_rdata;
    logic       m0_lock, m1_lock;
    logic [7:0] mem_addr_out, mem_data_out, mem_data_in;
    logic       mem_write;

    int checks;
    int failures;

    logic [7:0] mem [256];
    logic [7:0] mem_rd;

    mem_arbiter dut (
        .clk          (clk),
        .sync_nreset  (sync_nreset),
        .m0_req       (m0_req),
        .m0_we        (m0_we),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_gnt       (m0_gnt),
        .m0_rvalid    (m0_rvalid),
        .m0_rdata     (m0_rdata),
        .m1_req       (m1_req),
        .m1_we        (m1_we),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_gnt       (m1_gnt),
        .m1_rvalid    (m1_rvalid),
        .m1_rdata     (m1_rdata),
`ifdef MEM_ARB_LOCK_EN
        .m0_lock      (m0_lock),
        .m1_lock      (m1_lock),
`endif
        .mem_addr_out (mem_addr_out),
        .mem_data_out (mem_data_out),
        .mem_write    (mem_write),
        .mem_data_in  (mem_data_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: one-cycle registered read, preloaded while in reset.
    always @(posedge clk) begin
        if (!sync_nreset) begin
            mem[8'h10] <= 8'h5A;
            mem[8'h20] <= 8'hA1;
            mem[8'h30] <= 8'hB2;
            mem_rd     <= 8'h00;
        end else begin
            if (mem_write) mem[mem_addr_out] <= mem_data_out;
            mem_rd <= mem[mem_addr_out];
        end
    end
    assign mem_data_in = mem_rd;

    task automatic test_reset();
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10;
        #1;
        checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL rst_m0_gnt got=%0h exp=0", m0_gnt); end
        checks++; if (m1_gnt !== 1'b0) begin failures++; $display("FAIL rst_m1_gnt got=%0h exp=0", m1_gnt); end
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rst_mem_write got=%0h exp=0", mem_write); end
        checks++; if (mem_addr_out !== 8'h00) begin failures++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr_out); end
        @(negedge clk);
        #1;
        checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL rst_m0_rvalid got=%0h exp=0", m0_rvalid); end
        @(negedge clk);
        sync_nreset = 1'b1;
        #1;
        checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL rel_m0_gnt got=%0h exp=1", m0_gnt); end
        checks++; if (mem_addr_out !== 8'h10) begin failures++; $display("FAIL rel_mem_addr got=%0h exp=10", mem_addr_out); end
        @(negedge clk);
        m0_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10;
        #1;
        checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL rd_m0_gnt got=%0h exp=1", m0_gnt); end
        checks++; if (m1_gnt !== 1'b0) begin failures++; $display("FAIL rd_m1_gnt got=%0h exp=0", m1_gnt); end
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rd_mem_write got=%0h exp=0", mem_write); end
        @(negedge clk);
        m0_req = 1'b0;
        #1;
        checks++; if (m0_rvalid !== 1'b1) begin failures++; $display("FAIL rd_m0_rvalid got=%0h exp=1", m0_rvalid); end
        checks++; if (m0_rdata !== 8'h5A) begin failures++; $display("FAIL rd_m0_rdata got=%0h exp=5a", m0_rdata); end
        checks++; if (m1_rvalid !== 1'b0) begin failures++; $display("FAIL rd_m1_rvalid got=%0h exp=0", m1_rvalid); end
        checks++; if (m1_rdata !== 8'h00) begin failures++; $display("FAIL rd_m1_rdata got=%0h exp=0", m1_rdata); end
        @(negedge clk);
        #1;
        checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL rd_m0_rvalid_end got=%0h exp=0", m0_rvalid); end
        checks++; if (m0_rdata !== 8'h00) begin failures++; $display("FAIL rd_m0_rdata_end got=%0h exp=0", m0_rdata); end
    endtask

    task automatic test_write();
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h40; m1_wdata = 8'hC3;
        #1;
        checks++; if (m1_gnt !== 1'b1) begin failures++; $display("FAIL wr_m1_gnt got=%0h exp=1", m1_gnt); end
        checks++; if (m0_gnt !== 1'b0) begin failures++; $display("FAIL wr_m0_gnt got=%0h exp=0", m0_gnt); end
        checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL wr_mem_write got=%0h exp=1", mem_write); end
        checks++; if (mem_addr_out !== 8'h40) begin failures++; $display("FAIL wr_mem_addr got=%0h exp=40", mem_addr_out); end
        checks++; if (mem_data_out !== 8'hC3) begin failures++; $display("FAIL wr_mem_data got=%0h exp=c3", mem_data_out); end
        @(negedge clk);
        m1_req = 1'b0; m1_we = 1'b0;
        #1;
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL wr_mem_write_end got=%0h exp=0", mem_write); end
        checks++; if (mem_data_out !== 8'h00) begin failures++; $display("FAIL wr_mem_data_end got=%0h exp=0", mem_data_out); end
        checks++; if (m1_rvalid !== 1'b0) begin failures++; $display("FAIL wr_m1_rvalid got=%0h exp=0", m1_rvalid); end
        checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL wr_m0_rvalid got=%0h exp=0", m0_rvalid); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic       exp_g0;
        logic       prev0;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h20;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h30;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (i < 4) begin
                exp_g0   = (i % 2 == 0);
                exp_addr = exp_g0 ? 8'h20 : 8'h30;
                checks++; if (m0_gnt !== exp_g0) begin failures++; $display("FAIL b2b_m0_gnt[%0d] got=%0h exp=%0h", i, m0_gnt, exp_g0); end
                checks++; if (m1_gnt !== !exp_g0) begin failures++; $display("FAIL b2b_m1_gnt[%0d] got=%0h exp=%0h", i, m1_gnt, !exp_g0); end
                checks++; if (mem_addr_out !== exp_addr) begin failures++; $display("FAIL b2b_addr[%0d] got=%0h exp=%0h", i, mem_addr_out, exp_addr); end
            end
            if (i > 0) begin
                prev0    = ((i - 1) % 2 == 0);
                exp_data = prev0 ? 8'hA1 : 8'hB2;
                checks++; if (m0_rvalid !== prev0) begin failures++; $display("FAIL b2b_m0_rvalid[%0d] got=%0h exp=%0h", i, m0_rvalid, prev0); end
                checks++; if (m1_rvalid !== !prev0) begin failures++; $display("FAIL b2b_m1_rvalid[%0d] got=%0h exp=%0h", i, m1_rvalid, !prev0); end
                checks++; if ((prev0 ? m0_rdata : m1_rdata) !== exp_data) begin failures++; $display("FAIL b2b_rdata[%0d] got=%0h exp=%0h", i, prev0 ? m0_rdata : m1_rdata, exp_data); end
                checks++; if ((prev0 ? m1_rdata : m0_rdata) !== 8'h00) begin failures++; $display("FAIL b2b_other_rdata[%0d] got=%0h exp=0", i, prev0 ? m1_rdata : m0_rdata); end
            end
            @(negedge clk);
            if (i == 3) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10;
        #1;
        checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL mid_m0_gnt got=%0h exp=1", m0_gnt); end
        #2;
        sync_nreset = 1'b0;
        @(negedge clk);
        m0_req = 1'b0;
        #1;
        checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL mid_rvalid_in_rst got=%0h exp=0", m0_rvalid); end
        @(negedge clk);
        sync_nreset = 1'b1;
        m0_req = 1'b1; m0_addr = 8'h20;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h30;
        #1;
        checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL mid_rvalid_rel got=%0h exp=0", m0_rvalid); end
        checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL mid_tie_m0_gnt got=%0h exp=1", m0_gnt); end
        checks++; if (m1_gnt !== 1'b0) begin failures++; $display("FAIL mid_tie_m1_gnt got=%0h exp=0", m1_gnt); end
        @(negedge clk);
        m0_req = 1'b0;
        m1_req = 1'b0;
        #1;
        checks++; if (m0_rdata !== 8'hA1) begin failures++; $display("FAIL mid_post_rdata got=%0h exp=a1", m0_rdata); end
        @(negedge clk);
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock();
        int   m1_cnt;
        logic exp1;
        m1_cnt = 0;
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10; m0_lock = 1'b1;
        #1;
        checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL lock_first_gnt got=%0h exp=1", m0_gnt); end
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h30;
        for (int c = 1; c <= 18; c++) begin
            #1;
            exp1 = (c == 17);
            checks++; if (m1_gnt !== exp1) begin failures++; $display("FAIL lock_m1_gnt[%0d] got=%0h exp=%0h", c, m1_gnt, exp1); end
            checks++; if (m0_gnt !== !exp1) begin failures++; $display("FAIL lock_m0_gnt[%0d] got=%0h exp=%0h", c, m0_gnt, !exp1); end
            if (m1_gnt) m1_cnt++;
            @(negedge clk);
            if (c == 17) m1_req = 1'b0;
        end
        m0_req = 1'b0;
        m0_lock = 1'b0;
        checks++; if (m1_cnt !== 1) begin failures++; $display("FAIL lock_m1_gnt_count got=%0d exp=1", m1_cnt); end
        @(negedge clk);
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        sync_nreset = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00; m0_lock = 1'b0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00; m1_lock = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_ARB_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 8-bit memory port between two requesters: port 0 is the CPU instruction/data path, port 1 is a DMA/IO master.
- Performs one access per cycle and arbitrates round-robin.
- Returns read data one cycle after the grant, matching the memory's registered-read latency.
- Sits between the requesters and the memory's mem_addr_out/mem_data_out/mem_write/mem_data_in pins.

Parameters:
- DW, 8, data width
- AW, 8, address width
- LOCK_MAX, 16, maximum cycles a lock may hold the bus (lock feature only)

Ports:
- clk  input  1  clock, rising edge
- sync_nreset  input  1  reset, synchronous, active-low
- m0_req  input  1  port 0 access request; held until granted
- m0_we  input  1  port 0 write enable (1 = write)
- m0_addr  input  AW  port 0 address
- m0_wdata  input  DW  port 0 write data
- m0_gnt  output  1  port 0 access performed this cycle (combinational)
- m0_rvalid  output  1  port 0 read data valid (registered)
- m0_rdata  output  DW  port 0 read data
- m1_*  same set of seven ports as m0_*, for port 1
- mem_addr_out  output  AW  memory address
- mem_data_out  output  DW  memory write data
- mem_write  output  1  memory write strobe
- mem_data_in  input  DW  memory read data, valid one cycle after address

Behaviour:
- Reset:
  - Sampled on posedge clk while sync_nreset=0.
  - Clears last_grant to 1, so port 0 wins the first tie.
  - Clears rd_pend, rd_owner, and the lock state.
  - Forces all gnt/rvalid to 0.
  - Drives mem_addr_out=0, mem_data_out=0, mem_write=0.
- Grant (combinational, evaluated every cycle):
  - Only one requester: it is granted.
  - Both requesting: grant the port != last_grant.
  - None requesting: mem_* driven to 0 and no grant.
  - At most one gnt is high per cycle.
- Access:
  - mem_addr_out, mem_data_out and mem_write mux from the granted port in the same cycle.
  - mem_write = gnt & we.
  - mem_data_out is 0 when not writing.
- Requester rule:
  - req, we, addr and wdata stay stable from req rise until the cycle gnt=1 is seen.
  - Dropping req before grant is legal: the request is abandoned and nothing is performed.
- last_grant updates at posedge clk to the granted port in any cycle with a grant.
- Read return:
  - A granted read sets rd_pend=1 and rd_owner=port at the edge.
  - Next cycle: mX_rvalid=1 for rd_owner only, and mX_rdata=mem_data_in.
  - rdata is 0 on the non-owner port and whenever rvalid=0.
- Writes produce no rvalid.
- Back-to-back traffic:
  - A new grant may occur in the same cycle as the rvalid of the previous read; full throughput is one access per cycle.
  - Alternating ports under continuous contention gives a strict 0,1,0,1 pattern.
- Reset mid-operation: a pending rvalid is discarded; the next cycle after reset release shows rvalid=0.
- No X propagation: unused data paths drive 0.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- When defined:
  - Adds inputs m0_lock and m1_lock.
  - A granted port with lock=1 becomes owner from the next cycle.
  - The other port is never granted while the owner keeps lock=1.
  - The owner may issue any accesses meanwhile.
  - A lock counter runs; after LOCK_MAX consecutive owned cycles, ownership is forcibly released for one cycle and the other port wins if requesting.
  - Lock release or reset clears the owner and the counter.
- When undefined: no lock ports and pure round-robin.

Decomposition:
- Shared package mem_arb_pkg holds:
  - port-index constants PORT_M0=0, PORT_M1=1
  - DW/AW defaults
  - the lock-counter width, derived as clog2(LOCK_MAX+1)
- One sub-module, rr_arb2: 2-input round-robin grant logic, combinational, plus the last_grant register.
- Read-return and lock logic stay in mem_arbiter.

Test Plan:
- Reset with m0_req=1 held → all gnt=0, mem_write=0. After release: m0_gnt=1 the same cycle, mem_addr_out=m0_addr.
- m0 read addr 0x10, memory model returns 0x5A next cycle → m0_rvalid=1 and m0_rdata=0x5A one cycle after grant; m1_rvalid=0.
- m0 and m1 both request continuously (reads 0x20 and 0x30) → gnt pattern m0,m1,m0,m1. Each rvalid lands on the correct port with the matching data.
- m1 write addr 0x40 data 0xC3 while m0 idle → mem_write=1, mem_addr_out=0x40, mem_data_out=0xC3 for one cycle; no rvalid.
- m0 read granted, reset asserted next edge → after release, m0_rvalid=0 and last_grant is back to the reset value (port 0 wins the next tie).
- MEM_ARB_LOCK_EN: m0 holds lock with continuous req while m1 requests → m1 blocked for 16 owned cycles, then m1_gnt=1 exactly once.
